// File: rtl/rv32i_types.sv
// +----------------------------------------------------------------------------+
// | rv32i_types                                                                |
// | Shared RV32I encodings and the byte-lane mask helper.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rv32i_types;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_align_unit_lane.sv
// +----------------------------------------------------------------------------+
// | store_lane_align                                                           |
// | Combinational byte-lane placement for both beats of a store.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module store_lane_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rs2_data,
  output logic        funct3_ok,
  output logic        split,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1
);

  logic [3:0]  w_base;
  logic [7:0]  w_be_wide;
  logic [63:0] w_data_wide;

  always_comb begin
    w_base    = 4'b0000;
    funct3_ok = 1'b0;
    case (funct3)
      SB: begin w_base = 4'b0001; funct3_ok = 1'b1; end
      SH: begin w_base = 4'b0011; funct3_ok = 1'b1; end
      SW: begin w_base = 4'b1111; funct3_ok = 1'b1; end
      default: begin w_base = 4'b0000; funct3_ok = 1'b0; end
    endcase
  end

  // Upper halves of the widened shifts are exactly the spill-over into the next word.
  assign w_be_wide   = {4'b0000, w_base} << off;
  assign w_data_wide = {32'h0, rs2_data} << {off, 3'b000};

  assign be0    = w_be_wide[3:0];
  assign be1    = w_be_wide[7:4];
  assign wdata0 = w_data_wide[31:0]  & lane_mask(be0);
  assign wdata1 = w_data_wide[63:32] & lane_mask(be1);

  assign split = ((funct3 == SH) && (off == 2'b11)) ||
                 ((funct3 == SW) && (off != 2'b00));

endmodule

`default_nettype wire

// File: rtl/store_align_unit.sv
// +----------------------------------------------------------------------------+
// | store_align_unit                                                           |
// | Store FSM issuing one or two aligned memory beats per store request.       |
// | Build option: STORE_MISALIGNED_SPLIT_EN enables two-beat split stores.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module store_align_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] rs2_data,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_resp,
  output logic        store_done,
  output logic        store_fault
);

`ifdef STORE_MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1
  } state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic [31:0] r_mem_address, w_mem_address_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]  r_mem_be, w_mem_be_nxt;
  logic        r_done, w_done_nxt;
  logic        r_fault, w_fault_nxt;

  logic        w_funct3_ok, w_split, w_reject;
  logic [3:0]  w_be0, w_be1;
  logic [31:0] w_wdata0, w_wdata1;

  store_lane_align u_lane (
    .funct3    (funct3),
    .off       (addr[1:0]),
    .rs2_data  (rs2_data),
    .funct3_ok (w_funct3_ok),
    .split     (w_split),
    .be0       (w_be0),
    .be1       (w_be1),
    .wdata0    (w_wdata0),
    .wdata1    (w_wdata1)
  );

`ifdef STORE_MISALIGNED_SPLIT_EN
  logic        r_split, w_split_nxt;
  logic [3:0]  r_be1, w_be1_nxt;
  logic [31:0] r_wdata1, w_wdata1_nxt;

  assign w_reject = !w_funct3_ok;
`else
  logic w_unused_beat1;

  assign w_unused_beat1 = ^{w_be1, w_wdata1};
  assign w_reject       = !w_funct3_ok || w_split;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mem_address <= 32'h0;
      r_mem_wdata   <= 32'h0;
      r_mem_be      <= 4'b0000;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
      r_split       <= 1'b0;
      r_be1         <= 4'b0000;
      r_wdata1      <= 32'h0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_mem_be      <= w_mem_be_nxt;
      r_done        <= w_done_nxt;
      r_fault       <= w_fault_nxt;
`ifdef STORE_MISALIGNED_SPLIT_EN
      r_split       <= w_split_nxt;
      r_be1         <= w_be1_nxt;
      r_wdata1      <= w_wdata1_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_mem_address_nxt = r_mem_address;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_mem_be_nxt      = r_mem_be;
    w_done_nxt        = 1'b0;
    w_fault_nxt       = 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
    w_split_nxt       = r_split;
    w_be1_nxt         = r_be1;
    w_wdata1_nxt      = r_wdata1;
`endif
    case (r_state)
      IDLE: begin
        // The bus is driven to zero whenever no beat is outstanding.
        w_mem_address_nxt = 32'h0;
        w_mem_wdata_nxt   = 32'h0;
        w_mem_be_nxt      = 4'b0000;
        if (req_valid) begin
          if (w_reject) begin
            w_fault_nxt = 1'b1;
          end else begin
            w_state_nxt       = BEAT0;
            w_mem_address_nxt = {addr[31:2], 2'b00};
            w_mem_wdata_nxt   = w_wdata0;
            w_mem_be_nxt      = w_be0;
`ifdef STORE_MISALIGNED_SPLIT_EN
            w_split_nxt       = w_split;
            w_be1_nxt         = w_be1;
            w_wdata1_nxt      = w_wdata1;
`endif
          end
        end
      end
      BEAT0: begin
        if (mem_resp) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
          if (r_split) begin
            w_state_nxt       = BEAT1;
            w_mem_address_nxt = r_mem_address + 32'd4;
            w_mem_wdata_nxt   = r_wdata1;
            w_mem_be_nxt      = r_be1;
          end else begin
            w_state_nxt       = IDLE;
            w_done_nxt        = 1'b1;
            w_mem_address_nxt = 32'h0;
            w_mem_wdata_nxt   = 32'h0;
            w_mem_be_nxt      = 4'b0000;
          end
`else
          w_state_nxt       = IDLE;
          w_done_nxt        = 1'b1;
          w_mem_address_nxt = 32'h0;
          w_mem_wdata_nxt   = 32'h0;
          w_mem_be_nxt      = 4'b0000;
`endif
        end
      end
`ifdef STORE_MISALIGNED_SPLIT_EN
      BEAT1: begin
        if (mem_resp) begin
          w_state_nxt       = IDLE;
          w_done_nxt        = 1'b1;
          w_mem_address_nxt = 32'h0;
          w_mem_wdata_nxt   = 32'h0;
          w_mem_be_nxt      = 4'b0000;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign req_ready       = (r_state == IDLE);
  assign mem_write       = (r_state != IDLE);
  assign mem_address     = r_mem_address;
  assign mem_wdata       = r_mem_wdata;
  assign mem_byte_enable = r_mem_be;
  assign store_done      = r_done;
  assign store_fault     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_store_align_unit.sv
// +----------------------------------------------------------------------------+
// | tb_store_align_unit                                                        |
// | Directed self-checking bench for store_align_unit.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_store_align_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] rs2_data;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic        store_done;
  logic        store_fault;

  int checks = 0;
  int errors = 0;

  store_align_unit dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .funct3          (funct3),
    .addr            (addr),
    .rs2_data        (rs2_data),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .store_done      (store_done),
    .store_fault     (store_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs driven 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; funct3 = 3'b010; addr = 32'h100; rs2_data = 32'h55;
    tick();
    tick();
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", mem_write); end
    checks++; if ({store_done, store_fault} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {store_done, store_fault}); end
    checks++; if (mem_address !== 32'h0 || mem_wdata !== 32'h0 || mem_byte_enable !== 4'h0) begin
      errors++; $display("FAIL reset_bus got %h/%h/%b exp 0/0/0", mem_address, mem_wdata, mem_byte_enable); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    rst = 1'b0; req_valid = 1'b0; mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    tick();
    checks++; if (store_done !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL idle_resp_ignored got done=%b write=%b exp 0/0", store_done, mem_write); end
  endtask

  task automatic test_sb();
    req_valid = 1'b1; funct3 = 3'b000; addr = 32'h1002; rs2_data = 32'hAABBCCDD;
    tick();
    req_valid = 1'b0;
    checks++; if (mem_write !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL sb_write got write=%b ready=%b exp 1/0", mem_write, req_ready); end
    checks++; if (mem_address !== 32'h1000 || mem_byte_enable !== 4'b0100 || mem_wdata !== 32'h00DD0000) begin
      errors++; $display("FAIL sb_beat0 got %h/%b/%h exp 00001000/0100/00dd0000", mem_address, mem_byte_enable, mem_wdata); end
    tick();
    checks++; if (mem_write !== 1'b1 || mem_address !== 32'h1000 || mem_wdata !== 32'h00DD0000) begin
      errors++; $display("FAIL sb_hold got %b/%h/%h exp 1/00001000/00dd0000", mem_write, mem_address, mem_wdata); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (store_done !== 1'b1 || mem_write !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL sb_done got done=%b write=%b ready=%b exp 1/0/1", store_done, mem_write, req_ready); end
    tick();
    checks++; if (store_done !== 1'b0) begin errors++; $display("FAIL sb_done_pulse got %b exp 0", store_done); end
  endtask

  task automatic test_split_sh();
    req_valid = 1'b1; funct3 = 3'b001; addr = 32'h2003; rs2_data = 32'h00001234;
    tick();
    req_valid = 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
    checks++; if (mem_write !== 1'b1 || mem_address !== 32'h2000 || mem_byte_enable !== 4'b1000 || mem_wdata !== 32'h34000000) begin
      errors++; $display("FAIL sh_beat0 got %b/%h/%b/%h exp 1/00002000/1000/34000000", mem_write, mem_address, mem_byte_enable, mem_wdata); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (mem_write !== 1'b1 || store_done !== 1'b0 || mem_address !== 32'h2004 || mem_byte_enable !== 4'b0001 || mem_wdata !== 32'h00000012) begin
      errors++; $display("FAIL sh_beat1 got %b/%b/%h/%b/%h exp 1/0/00002004/0001/00000012", mem_write, store_done, mem_address, mem_byte_enable, mem_wdata); end
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (store_done !== 1'b1 || mem_write !== 1'b0) begin
      errors++; $display("FAIL sh_done got done=%b write=%b exp 1/0", store_done, mem_write); end
    tick();
`else
    checks++; if (mem_write !== 1'b0 || store_fault !== 1'b1 || store_done !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL sh_reject got write=%b fault=%b done=%b ready=%b exp 0/1/0/1", mem_write, store_fault, store_done, req_ready); end
    tick();
    checks++; if (store_fault !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL sh_reject_pulse got fault=%b write=%b exp 0/0", store_fault, mem_write); end
`endif
  endtask

  task automatic test_split_sw_wrap();
    req_valid = 1'b1; funct3 = 3'b010; addr = 32'hFFFFFFFE; rs2_data = 32'hDEADBEEF;
    tick();
    req_valid = 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
    checks++; if (mem_address !== 32'hFFFFFFFC || mem_byte_enable !== 4'b1100 || mem_wdata !== 32'hBEEF0000) begin
      errors++; $display("FAIL sw_beat0 got %h/%b/%h exp fffffffc/1100/beef0000", mem_address, mem_byte_enable, mem_wdata); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (mem_address !== 32'h0 || mem_byte_enable !== 4'b0011 || mem_wdata !== 32'h0000DEAD || mem_write !== 1'b1) begin
      errors++; $display("FAIL sw_beat1 got %h/%b/%h/%b exp 00000000/0011/0000dead/1", mem_address, mem_byte_enable, mem_wdata, mem_write); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (store_done !== 1'b1) begin errors++; $display("FAIL sw_done got %b exp 1", store_done); end
    tick();
`else
    checks++; if (mem_write !== 1'b0 || store_fault !== 1'b1) begin
      errors++; $display("FAIL sw_reject got write=%b fault=%b exp 0/1", mem_write, store_fault); end
    tick();
`endif
  endtask

  task automatic test_bad_funct3();
    req_valid = 1'b1; funct3 = 3'b011; addr = 32'h3000; rs2_data = 32'h12345678;
    tick();
    req_valid = 1'b0;
    checks++; if (store_fault !== 1'b1 || store_done !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bad_funct3 got fault=%b done=%b write=%b ready=%b exp 1/0/0/1", store_fault, store_done, mem_write, req_ready); end
    tick();
    checks++; if (store_fault !== 1'b0) begin errors++; $display("FAIL bad_funct3_pulse got %b exp 0", store_fault); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; funct3 = 3'b010; addr = 32'h40; rs2_data = 32'h11223344;
    tick();
    req_valid = 1'b0;
    checks++; if (mem_write !== 1'b1 || mem_wdata !== 32'h11223344 || mem_byte_enable !== 4'b1111) begin
      errors++; $display("FAIL mid_beat0 got %b/%h/%b exp 1/11223344/1111", mem_write, mem_wdata, mem_byte_enable); end
    rst = 1'b1; mem_resp = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (mem_write !== 1'b0 || store_done !== 1'b0 || mem_address !== 32'h0) begin
      errors++; $display("FAIL mid_rst got write=%b done=%b addr=%h exp 0/0/0", mem_write, store_done, mem_address); end
    tick();
    mem_resp = 1'b0;
    checks++; if (store_done !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL mid_late_resp got done=%b write=%b exp 0/0", store_done, mem_write); end
    req_valid = 1'b1; funct3 = 3'b010; addr = 32'h80; rs2_data = 32'hCAFEBABE;
    tick();
    req_valid = 1'b0;
    checks++; if (mem_address !== 32'h80 || mem_wdata !== 32'hCAFEBABE || mem_write !== 1'b1) begin
      errors++; $display("FAIL mid_next_beat0 got %h/%h/%b exp 00000080/cafebabe/1", mem_address, mem_wdata, mem_write); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (store_done !== 1'b1) begin errors++; $display("FAIL mid_next_done got %b exp 1", store_done); end
    tick();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; funct3 = 3'b010; addr = 32'h0; rs2_data = 32'hA5A5A5A5;
    tick();
    addr = 32'h4; rs2_data = 32'h5A5A5A5A;
    checks++; if (req_ready !== 1'b0 || mem_address !== 32'h0 || mem_wdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL b2b_first got ready=%b %h/%h exp 0/00000000/a5a5a5a5", req_ready, mem_address, mem_wdata); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (store_done !== 1'b1 || req_ready !== 1'b1 || mem_write !== 1'b0) begin
      errors++; $display("FAIL b2b_done1 got done=%b ready=%b write=%b exp 1/1/0", store_done, req_ready, mem_write); end
    tick();
    req_valid = 1'b0;
    checks++; if (mem_write !== 1'b1 || mem_address !== 32'h4 || mem_wdata !== 32'h5A5A5A5A || store_done !== 1'b0) begin
      errors++; $display("FAIL b2b_second got %b/%h/%h/%b exp 1/00000004/5a5a5a5a/0", mem_write, mem_address, mem_wdata, store_done); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    checks++; if (store_done !== 1'b1 || store_fault !== 1'b0) begin
      errors++; $display("FAIL b2b_done2 got done=%b fault=%b exp 1/0", store_done, store_fault); end
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; funct3 = 3'b000; addr = 32'h0; rs2_data = 32'h0; mem_resp = 1'b0;
    #1;
    test_reset();
    test_sb();
    test_split_sh();
    test_split_sw_wrap();
    test_bad_funct3();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
